// File: rtl/comparator_scan_sequencer_if.sv
// Injector fire/ready handshake and per-point result stream
// between the scan sequencer and its neighbours.
interface comparator_scan_sequencer_if #(
    parameter int DAC_W = 10,
    parameter int CNT_W = 16
) ();
    logic             fire_pulse;
    logic             pulser_ready;
    logic             compout_last;
    logic             result_valid;
    logic             result_ready;
    logic [DAC_W-1:0] result_dac;
    logic [CNT_W-1:0] result_hits;

    modport master (
        output fire_pulse,
        output result_valid,
        output result_dac,
        output result_hits,
        input  pulser_ready,
        input  compout_last,
        input  result_ready
    );

    modport slave (
        input  fire_pulse,
        input  result_valid,
        input  result_dac,
        input  result_hits,
        output pulser_ready,
        output compout_last,
        output result_ready
    );
endinterface

// File: rtl/comparator_scan_sequencer.sv
// Threshold-DAC scan initiator: load DAC, settle, fire N injector
// pulses, count comparator hits, emit one result per DAC point.
module comparator_scan_sequencer #(
    parameter int DAC_W   = 10,
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DAC_W-1:0] dac_start,
    input  logic [DAC_W-1:0] dac_stop,
    input  logic [DAC_W-1:0] dac_step,
    input  logic [CNT_W-1:0] pulses_per_point,
    input  logic [7:0]       settle_cycles,
    output logic [DAC_W-1:0] dac_value,
    output logic             dac_load,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    comparator_scan_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TMO_CYC + 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_FIRE,
        S_WAIT,
        S_REPORT,
        S_STEP,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nx;
    logic [DAC_W-1:0] r_dac, w_dac_nx;
    logic [DAC_W-1:0] r_stop, w_stop_nx;
    logic [DAC_W-1:0] r_step, w_step_nx;
    logic [CNT_W-1:0] r_ppp, w_ppp_nx;
    logic [CNT_W-1:0] r_hits, w_hits_nx;
    logic [CNT_W-1:0] r_pcnt, w_pcnt_nx;
    logic [7:0]       r_set, w_set_nx;
    logic [WD_W-1:0]  r_wd, w_wd_nx;
    logic             r_load, w_load_nx;
    logic             r_fire, w_fire_nx;
    logic             r_rv, w_rv_nx;
    logic [DAC_W-1:0] r_rdac, w_rdac_nx;
    logic [CNT_W-1:0] r_rhits, w_rhits_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             r_tmo, w_tmo_nx;

    logic [DAC_W:0]   w_next;
    logic [CNT_W-1:0] w_hits_inc;
    logic [CNT_W-1:0] w_pcnt_inc;

    assign w_next     = {1'b0, r_dac} + {1'b0, r_step};
    assign w_hits_inc = r_hits + {{(CNT_W-1){1'b0}}, bus.compout_last};
    assign w_pcnt_inc = r_pcnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_dac_nx   = r_dac;
        w_stop_nx  = r_stop;
        w_step_nx  = r_step;
        w_ppp_nx   = r_ppp;
        w_hits_nx  = r_hits;
        w_pcnt_nx  = r_pcnt;
        w_set_nx   = r_set;
        w_wd_nx    = r_wd;
        w_load_nx  = 1'b0;
        w_fire_nx  = r_fire;
        w_rv_nx    = r_rv;
        w_rdac_nx  = r_rdac;
        w_rhits_nx = r_rhits;
        w_tmo_nx   = r_tmo;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_dac_nx   = dac_start;
                    w_stop_nx  = dac_stop;
                    w_step_nx  = dac_step;
                    w_ppp_nx   = pulses_per_point;
                    w_tmo_nx   = 1'b0;
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load_nx  = 1'b1;
                w_hits_nx  = '0;
                w_pcnt_nx  = '0;
                w_set_nx   = settle_cycles;
                w_state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_set <= 8'd1) begin
                    if (r_ppp == '0) begin
                        w_rv_nx    = 1'b1;
                        w_rdac_nx  = r_dac;
                        w_rhits_nx = '0;
                        w_state_nx = S_REPORT;
                    end else begin
                        w_fire_nx  = bus.pulser_ready;
                        w_wd_nx    = '0;
                        w_state_nx = S_FIRE;
                    end
                end else begin
                    w_set_nx = r_set - 8'd1;
                end
            end
            S_FIRE: begin
                w_wd_nx = r_wd + WD_ONE;
                if (r_fire && !bus.pulser_ready) begin
                    w_fire_nx  = 1'b0;
                    w_wd_nx    = '0;
                    w_state_nx = S_WAIT;
                end else begin
                    if (!r_fire) w_fire_nx = bus.pulser_ready;
                    if (r_wd == WD_LAST) begin
                        w_fire_nx  = 1'b0;
                        w_tmo_nx   = 1'b1;
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                w_wd_nx = r_wd + WD_ONE;
                // ready was already seen low on entry, so high here is the rising edge
                if (bus.pulser_ready) begin
                    w_hits_nx = w_hits_inc;
                    w_pcnt_nx = w_pcnt_inc;
                    w_wd_nx   = '0;
                    if (w_pcnt_inc == r_ppp) begin
                        w_rv_nx    = 1'b1;
                        w_rdac_nx  = r_dac;
                        w_rhits_nx = w_hits_inc;
                        w_state_nx = S_REPORT;
                    end else begin
                        w_fire_nx  = 1'b1;
                        w_state_nx = S_FIRE;
                    end
                end else if (r_wd == WD_LAST) begin
                    w_tmo_nx   = 1'b1;
                    w_state_nx = S_DONE;
                end
            end
            S_REPORT: begin
                if (bus.result_ready) begin
                    w_rv_nx    = 1'b0;
                    w_state_nx = S_STEP;
                end
            end
            S_STEP: begin
                if (r_step == '0 || w_next[DAC_W] ||
                    w_next[DAC_W-1:0] > r_stop) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_dac_nx   = w_next[DAC_W-1:0];
                    w_state_nx = S_LOAD;
                end
            end
        endcase
        if (abort) begin
            w_state_nx = S_IDLE;
            w_fire_nx  = 1'b0;
            w_rv_nx    = 1'b0;
            w_load_nx  = 1'b0;
        end
        w_busy_nx = (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
        w_done_nx = (w_state_nx == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dac   <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_ppp   <= '0;
            r_hits  <= '0;
            r_pcnt  <= '0;
            r_set   <= '0;
            r_wd    <= '0;
            r_load  <= 1'b0;
            r_fire  <= 1'b0;
            r_rv    <= 1'b0;
            r_rdac  <= '0;
            r_rhits <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_dac   <= w_dac_nx;
            r_stop  <= w_stop_nx;
            r_step  <= w_step_nx;
            r_ppp   <= w_ppp_nx;
            r_hits  <= w_hits_nx;
            r_pcnt  <= w_pcnt_nx;
            r_set   <= w_set_nx;
            r_wd    <= w_wd_nx;
            r_load  <= w_load_nx;
            r_fire  <= w_fire_nx;
            r_rv    <= w_rv_nx;
            r_rdac  <= w_rdac_nx;
            r_rhits <= w_rhits_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_tmo   <= w_tmo_nx;
        end
    end

    assign dac_value        = r_dac;
    assign dac_load         = r_load;
    assign busy             = r_busy;
    assign done             = r_done;
    assign timeout_err      = r_tmo;
    assign bus.fire_pulse   = r_fire;
    assign bus.result_valid = r_rv;
    assign bus.result_dac   = r_rdac;
    assign bus.result_hits  = r_rhits;
endmodule

// File: tb/tb_comparator_scan_sequencer.sv
// Scoreboard bench for the comparator scan sequencer with a
// behavioural injector model and result consumer.
module tb_comparator_scan_sequencer;
    localparam int DW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] dac_start = '0;
    logic [DW-1:0] dac_stop = '0;
    logic [DW-1:0] dac_step = '0;
    logic [CW-1:0] ppp = '0;
    logic [7:0]    settle = '0;
    logic [DW-1:0] dac_value;
    logic          dac_load, busy, done, timeout_err;

    comparator_scan_sequencer_if #(.DAC_W(DW), .CNT_W(CW)) bus ();

    comparator_scan_sequencer #(.DAC_W(DW), .CNT_W(CW), .TMO_CYC(255)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dac_start(dac_start), .dac_stop(dac_stop), .dac_step(dac_step),
        .pulses_per_point(ppp), .settle_cycles(settle),
        .dac_value(dac_value), .dac_load(dac_load), .busy(busy),
        .done(done), .timeout_err(timeout_err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int dac; int hits; } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int hsk = 0, loads = 0, fires = 0, nres = 0, icnt = 0;
    bit stuck = 0, alt = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    initial begin
        bus.pulser_ready = 1'b1;
        bus.compout_last = 1'b0;
        bus.result_ready = 1'b1;
    end

    // injector: drops ready on fire, returns it 4 cycles later with compout
    always @(negedge clk) begin
        if (dac_load) loads++;
        if (bus.fire_pulse) fires++;
        if (rst) begin
            bus.pulser_ready = 1'b1;
            icnt = 0;
        end else if (bus.pulser_ready) begin
            if (bus.fire_pulse && !stuck) begin
                bus.pulser_ready = 1'b0;
                icnt = 3;
            end
        end else if (icnt > 0) begin
            icnt--;
        end else begin
            bus.compout_last = alt ? ~hsk[0] : 1'b1;
            hsk++;
            bus.pulser_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.result_valid && bus.result_ready) begin
            nres++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", nres, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_dac", bus.result_dac, e.dac);
                chk("result_hits", bus.result_hits, e.hits);
            end
        end
    end

    task automatic chk_reset(string tag);
        chk({tag, "_dac_value"}, dac_value, 0);
        chk({tag, "_dac_load"}, dac_load, 0);
        chk({tag, "_fire"}, bus.fire_pulse, 0);
        chk({tag, "_rvalid"}, bus.result_valid, 0);
        chk({tag, "_rdac"}, bus.result_dac, 0);
        chk({tag, "_rhits"}, bus.result_hits, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    task automatic set_ready(logic v);
        @(posedge clk);
        #1 bus.result_ready = v;
    endtask

    task automatic wait_done(string tag, int lim);
        int k = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic do_start(string tag, int s);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_tmo_clr"}, timeout_err, 0);
        chk({tag, "_load_c1"}, dac_load, 0);
        @(negedge clk);
        chk({tag, "_load_c2"}, dac_load, 1);
        chk({tag, "_dac_value"}, dac_value, s);
    endtask

    task automatic set_cfg(int s, int e, int st, int p, int se, bit pat);
        dac_start = DW'(s);
        dac_stop  = DW'(e);
        dac_step  = DW'(st);
        ppp       = CW'(p);
        settle    = 8'(se);
        alt       = pat;
    endtask

    task automatic run_scan(string tag, int s, int e, int st, int p,
                            int se, bit pat);
        int pt = s, nx, npts = 0;
        int h0, l0, f0, r0;
        set_cfg(s, e, st, p, se, pat);
        while (1) begin
            exp_q.push_back('{pt, (p == 0) ? 0 : (pat ? p / 2 : p)});
            npts++;
            nx = pt + st;
            if (st == 0 || nx > 1023 || nx > e) break;
            pt = nx;
        end
        h0 = hsk; l0 = loads; f0 = fires; r0 = nres;
        do_start(tag, s);
        wait_done(tag, 20000);
        @(negedge clk);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        chk({tag, "_nres"}, nres - r0, npts);
        chk({tag, "_hsk"}, hsk - h0, npts * p);
        chk({tag, "_loads"}, loads - l0, npts);
        if (p == 0) chk({tag, "_no_fire"}, fires - f0, 0);
    endtask

    task automatic wait_sig_valid(string tag, int lim);
        int k = 0;
        while (!bus.result_valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid_seen"}, bus.result_valid, 1);
    endtask

    task automatic chk_aborted(string tag);
        chk({tag, "_fire"}, bus.fire_pulse, 0);
        chk({tag, "_rvalid"}, bus.result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int f0, r0, k;
        logic [DW-1:0] sd;
        logic [CW-1:0] sh;
        bit stable;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        run_scan("sweep", 0, 20, 10, 4, 3, 1'b0);
        run_scan("alt", 0, 0, 1, 8, 0, 1'b1);
        run_scan("ppp0", 0, 20, 10, 0, 0, 1'b0);
        run_scan("carry", 1020, 1023, 10, 2, 1, 1'b0);
        run_scan("rev", 5, 2, 1, 2, 0, 1'b0);
        run_scan("step0", 7, 100, 0, 2, 0, 1'b0);

        // backpressure
        set_cfg(100, 100, 1, 2, 0, 1'b0);
        exp_q.push_back('{100, 2});
        set_ready(1'b0);
        do_start("bp", 100);
        wait_sig_valid("bp", 2000);
        sd = bus.result_dac;
        sh = bus.result_hits;
        f0 = fires;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!bus.result_valid || bus.result_dac != sd ||
                bus.result_hits != sh) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_fire", fires - f0, 0);
        set_ready(1'b1);
        wait_done("bp", 100);
        chk("bp_q_empty", exp_q.size(), 0);

        // watchdog
        stuck = 1'b1;
        set_cfg(3, 3, 1, 2, 0, 1'b0);
        r0 = nres;
        do_start("wd", 3);
        wait_done("wd", 600);
        chk("wd_tmo", timeout_err, 1);
        chk("wd_fire", bus.fire_pulse, 0);
        chk("wd_nres", nres - r0, 0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        run_scan("after_wd", 9, 9, 1, 2, 0, 1'b0);

        // abort mid-WAIT
        set_cfg(0, 50, 10, 4, 3, 1'b0);
        do_start("abw", 0);
        k = 0;
        while (!(bus.fire_pulse == 1'b0 && bus.pulser_ready == 1'b0 &&
                 busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("abw_in_wait", bus.pulser_ready, 0);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk_aborted("abw");
        repeat (10) @(negedge clk);

        // abort mid-REPORT
        set_cfg(40, 40, 1, 1, 0, 1'b0);
        set_ready(1'b0);
        do_start("abr", 40);
        wait_sig_valid("abr", 200);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk_aborted("abr");
        set_ready(1'b1);
        repeat (5) @(negedge clk);

        // reset mid-scan
        set_cfg(0, 100, 10, 4, 2, 1'b0);
        do_start("rstm", 0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid");
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
